// File: rtl/ps2_kb_writer_pkg.sv
// ps2_kb_writer_pkg: scan-code constants and receiver state encoding shared by the PS/2 writer
package ps2_kb_writer_pkg;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver (pin sync, falling-edge detect, frame FSM, inactivity timeout)
//   clk, rst          system clock, sync active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 pins
//   rx_byte           last received data byte (valid with rx_valid)
//   rx_valid          one-cycle pulse: good frame received
//   rx_err            one-cycle pulse: parity error, stop bit 0 or timeout
module ps2_rx
    import ps2_kb_writer_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT);
    logic [2:0]    c_q;
    logic [1:0]    d_q;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d, valid_q, valid_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fall, dat;
    // c_q[2] is the previous synced clock sample, c_q[1] the current one
    assign fall     = c_q[2] & ~c_q[1];
    assign dat      = d_q[1];
    assign rx_byte  = sh_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tmo_d   = (fall || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
        unique case (state_q)
            ST_IDLE: if (fall && !dat) begin
                state_d = ST_DATA;
                bit_d   = 3'd0;
            end
            ST_DATA: if (fall) begin
                sh_d    = {dat, sh_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? ST_PARITY : ST_DATA;
            end
            ST_PARITY: if (fall) begin
                par_d   = dat;
                state_d = ST_STOP;
            end
            ST_STOP: if (fall) begin
                valid_d = (^sh_q ^ par_q) & dat;
                err_d   = ~((^sh_q ^ par_q) & dat);
                state_d = ST_IDLE;
            end
        endcase
        // a stalled partial frame is abandoned after TIMEOUT edge-free cycles
        if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= 3'b111;
            d_q     <= 2'b11;
            state_q <= ST_IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            c_q     <= {c_q[1:0], ps2_clk};
            d_q     <= {d_q[0], ps2_dat};
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: rtl/ps2_kb_writer.sv
// ps2_kb_writer: filters PS/2 scan codes and writes make codes into the ps2-side buffer bank
//   clk, rst          system clock, sync active-high reset
//   ps2_clk, ps2_dat  raw PS/2 pins
//   swap_req          one-cycle CPU request to swap banks
//   buf_slt           bank select (0: ps2 side writes bank0)
//   ps2_addr/ps2_data/wea  write port into the ps2-side bank
//   kb_count          byte count of the bank last handed to the CPU
//   kb_ovf            sticky: code dropped on a full bank, cleared by swap
//   frame_err         one-cycle pulse on a bad or timed-out frame
module ps2_kb_writer
    import ps2_kb_writer_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_dat,
    input  logic              swap_req,
    output logic              buf_slt,
    output logic [ADDR_W-1:0] ps2_addr,
    output logic [7:0]        ps2_data,
    output logic              wea,
    output logic [ADDR_W:0]   kb_count,
    output logic              kb_ovf,
    output logic              frame_err
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);
    logic [7:0]    rx_byte, code_q, code_d, data_q, data_d;
    logic          rx_valid, rx_err;
    logic          brk_q, brk_d, req_q, req_d, wea_q, wea_d;
    logic          slt_q, slt_d, ovf_q, ovf_d, ferr_q;
    logic [ADDR_W:0] ptr_q, ptr_d, cnt_q, cnt_d, cnt, nxt;
    logic          full;
    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );
    // the pointer advances the cycle after wea so ps2_addr shows the written address during wea;
    // nxt folds that pending increment in for fullness and the swap count
    assign nxt  = ptr_q + {{ADDR_W{1'b0}}, wea_q};
    assign full = nxt == DEPTH;
    assign cnt  = nxt;
    always_comb begin
        brk_d  = rx_valid ? (rx_byte == SC_BREAK || (rx_byte == SC_EXT && brk_q)) : brk_q;
        req_d  = rx_valid && rx_byte != SC_BREAK && rx_byte != SC_EXT && !brk_q;
        code_d = rx_valid ? rx_byte : code_q;
        // a swap in the same cycle empties the bank, so the write then goes to the new bank
        wea_d  = req_q && (swap_req || !full);
        data_d = wea_d ? code_q : data_q;
        ptr_d  = swap_req ? '0 : cnt;
        slt_d  = slt_q ^ swap_req;
        cnt_d  = swap_req ? cnt : cnt_q;
        ovf_d  = !swap_req && (ovf_q || (req_q && full));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q  <= 1'b0;
            req_q  <= 1'b0;
            code_q <= '0;
            wea_q  <= 1'b0;
            data_q <= '0;
            ptr_q  <= '0;
            slt_q  <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            brk_q  <= brk_d;
            req_q  <= req_d;
            code_q <= code_d;
            wea_q  <= wea_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
            slt_q  <= slt_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            ferr_q <= rx_err;
        end
    end
    assign buf_slt   = slt_q;
    assign ps2_addr  = ptr_q[ADDR_W-1:0];
    assign ps2_data  = data_q;
    assign wea       = wea_q;
    assign kb_count  = cnt_q;
    assign kb_ovf    = ovf_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_kb_writer.sv
// tb_ps2_kb_writer: directed self-checking bench for ps2_kb_writer
module tb_ps2_kb_writer;
    import ps2_kb_writer_pkg::*;
    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1, swap_req = 1'b0;
    logic       buf_slt, wea, kb_ovf, frame_err;
    logic [5:0] ps2_addr;
    logic [7:0] ps2_data;
    logic [6:0] kb_count;
    int         errors = 0, checks = 0, ferr = 0;
    logic [5:0] wa[$];
    logic [7:0] wd[$];
    logic       ws[$];

    ps2_kb_writer #(.ADDR_W(6), .TIMEOUT(1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .swap_req  (swap_req),
        .buf_slt   (buf_slt),
        .ps2_addr  (ps2_addr),
        .ps2_data  (ps2_data),
        .wea       (wea),
        .kb_count  (kb_count),
        .kb_ovf    (kb_ovf),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wea) begin
            wa.push_back(ps2_addr);
            wd.push_back(ps2_data);
            ws.push_back(buf_slt);
        end
        if (frame_err) ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            #40 ps2_clk = 1'b0;
            #40 ps2_clk = 1'b1;
        end
    endtask

    task automatic frame_raw(input logic [7:0] b, input logic par, input logic stop);
        send_bits({stop, par, b, 1'b0}, 11);
        #100;
    endtask

    task automatic frame(input logic [7:0] b);
        frame_raw(b, ~^b, 1'b1);
    endtask

    task automatic do_reset;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_swap;
        @(negedge clk) swap_req = 1'b1;
        @(negedge clk) swap_req = 1'b0;
    endtask

    initial begin
        int n0, f0, bad;
        logic found;
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_slt", buf_slt, 0);
        chk("rst_addr", ps2_addr, 0);
        chk("rst_data", ps2_data, 0);
        chk("rst_wea", wea, 0);
        chk("rst_cnt", kb_count, 0);
        chk("rst_ovf", kb_ovf, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;
        // 1: single make code
        n0 = wa.size();
        frame(8'h1C);
        chk("t1_nwr", wa.size() - n0, 1);
        chk("t1_addr", wa[n0], 0);
        chk("t1_data", wd[n0], 8'h1C);
        chk("t1_slt", ws[n0], 0);
        // 2: break / extended filtering then swap
        do_reset();
        n0 = wa.size();
        frame(8'h1C); frame(8'hF0); frame(8'h1C); frame(8'hE0); frame(8'h75);
        chk("t2_nwr", wa.size() - n0, 2);
        chk("t2_a0", wa[n0], 0);
        chk("t2_d0", wd[n0], 8'h1C);
        chk("t2_a1", wa[n0+1], 1);
        chk("t2_d1", wd[n0+1], 8'h75);
        do_swap();
        chk("t2_slt", buf_slt, 1);
        chk("t2_cnt", kb_count, 2);
        chk("t2_addr", ps2_addr, 0);
        // 3: bad parity, bad stop, then good frame
        do_reset();
        n0 = wa.size(); f0 = ferr;
        frame_raw(8'h1C, 1'b1, 1'b1);
        frame_raw(8'h1C, 1'b0, 1'b0);
        chk("t3_ferr", ferr - f0, 2);
        chk("t3_nowr", wa.size() - n0, 0);
        frame(8'h32);
        chk("t3_nwr", wa.size() - n0, 1);
        chk("t3_addr", wa[n0], 0);
        chk("t3_data", wd[n0], 8'h32);
        // 4: timeout after 4 data bits
        do_reset();
        n0 = wa.size(); f0 = ferr;
        send_bits({1'b1, 1'b0, 8'h15, 1'b0}, 5);
        #12000;
        chk("t4_ferr", ferr - f0, 1);
        chk("t4_idle", 32'(dut.u_rx.state_q), 32'(ST_IDLE));
        chk("t4_nowr", wa.size() - n0, 0);
        frame(8'h15);
        chk("t4_nwr", wa.size() - n0, 1);
        chk("t4_addr", wa[n0], 0);
        chk("t4_data", wd[n0], 8'h15);
        chk("t4_ferr2", ferr - f0, 1);
        // 5: fill bank, overflow, swap
        do_reset();
        n0 = wa.size();
        for (int i = 0; i < 65; i++) frame(8'h01 + 8'(i));
        chk("t5_nwr", wa.size() - n0, 64);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (wa[n0+i] !== 6'(i) || wd[n0+i] !== 8'h01 + 8'(i) || ws[n0+i] !== 1'b0) bad++;
        chk("t5_seq", bad, 0);
        chk("t5_ovf", kb_ovf, 1);
        do_swap();
        chk("t5_cnt", kb_count, 64);
        chk("t5_ovf0", kb_ovf, 0);
        chk("t5_addr", ps2_addr, 0);
        n0 = wa.size();
        frame(8'h2A);
        chk("t5_nwr2", wa.size() - n0, 1);
        chk("t5_a2", wa[n0], 0);
        chk("t5_s2", ws[n0], 1);
        // 6: swap coinciding with a write, then reset mid-frame
        do_reset();
        for (int i = 0; i < 5; i++) frame(8'h20 + 8'(i));
        n0 = wa.size();
        send_bits({1'b1, ~^8'h2B, 8'h2B, 1'b0}, 10);
        ps2_dat = 1'b1;
        #40 ps2_clk = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = wea;
        end
        chk("t6_wea_seen", found, 1);
        swap_req = 1'b1;
        @(negedge clk) swap_req = 1'b0;
        ps2_clk = 1'b1;
        chk("t6_cnt", kb_count, 6);
        chk("t6_addr", ps2_addr, 0);
        chk("t6_slt", buf_slt, 1);
        chk("t6_wea1", wea, 0);
        #100;
        chk("t6_nwr", wa.size() - n0, 1);
        chk("t6_wa", wa[n0], 5);
        chk("t6_wd", wd[n0], 8'h2B);
        chk("t6_ws", ws[n0], 0);
        f0 = ferr;
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("t6_r_slt", buf_slt, 0);
        chk("t6_r_addr", ps2_addr, 0);
        chk("t6_r_data", ps2_data, 0);
        chk("t6_r_wea", wea, 0);
        chk("t6_r_cnt", kb_count, 0);
        chk("t6_r_ovf", kb_ovf, 0);
        chk("t6_r_ferr", frame_err, 0);
        rst = 1'b0;
        n0 = wa.size();
        frame(8'h1C);
        chk("t6_post_nwr", wa.size() - n0, 1);
        chk("t6_post_a", wa[n0], 0);
        chk("t6_post_d", wd[n0], 8'h1C);
        chk("t6_post_ferr", ferr - f0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
